gpio_pad_ctrl: RTL and testbench

Per-pad GPIO control stage that sits directly upstream of the user-area pad array and drives its `io_out`, `oeb`, `inp_dis` and `dm[2:0]` inputs for one pad. It holds a serially loaded configuration word, shifted in through a daisy-chain shared by all pads and committed by a load strobe. It muxes pad control between the management SoC and the user project, and returns the pad input to both sides, with a synchronized copy for management.

---
 rtl/gpio_cfg_pkg.sv | 24 ++
 rtl/gpio_in_sync.sv | 34 +++
 rtl/gpio_pad_ctrl.sv | 122 ++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Configuration word layout for one GPIO pad control stage.
// Holds the word width, the bit index of every field and the power-on
// configuration (management owns the pad, output disabled, dm=3'b110).
package gpio_cfg_pkg;

   localparam int unsigned CFG_BITS = 13;

   // Field bit positions inside the configuration word
   localparam int unsigned DM_MSB      = 12;
   localparam int unsigned DM_LSB      = 10;
   localparam int unsigned VTRIP_SEL   = 9;
   localparam int unsigned SLOW_SEL    = 8;
   localparam int unsigned ANALOG_POL  = 7;
   localparam int unsigned ANALOG_SEL  = 6;
   localparam int unsigned ANALOG_EN   = 5;
   localparam int unsigned IB_MODE_SEL = 4;
   localparam int unsigned INP_DIS     = 3;
   localparam int unsigned HOLDOVER    = 2;
   localparam int unsigned OEB         = 1;
   localparam int unsigned MGMT_ENA    = 0;

   localparam logic [CFG_BITS-1:0] RESET_CFG = 13'h1803;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for the asynchronous pad input.
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-high reset, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output, two clock edges after d settles
module gpio_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Per-pad GPIO control stage.
// Holds a configuration word loaded over a shared serial daisy-chain and
// committed by a load strobe, and muxes the pad drive between the management
// SoC and the user project.
// Ports:
//   serial_clock, reset                  - only clock, async active-high reset
//   serial_enable, serial_data_in        - shift one chain bit per enabled cycle
//   serial_load                          - commit strobe (wins over serial_enable)
//   serial_data_out                      - chain output, MSB of the shift register
//   cfg_err                              - sticky, last load had a wrong bit count
//   cfg_word                             - active configuration (debug)
//   mgmt_gpio_out/oeb, mgmt_gpio_in      - management side
//   user_gpio_out/oeb, user_gpio_in      - user side
//   pad_gpio_in                          - asynchronous pad input
//   pad_gpio_out/outenb/inp_dis/dm       - pad control outputs
module gpio_pad_ctrl
   import gpio_cfg_pkg::DM_MSB, gpio_cfg_pkg::DM_LSB, gpio_cfg_pkg::INP_DIS,
          gpio_cfg_pkg::OEB, gpio_cfg_pkg::MGMT_ENA;
#(
   parameter int unsigned          CFG_BITS  = gpio_cfg_pkg::CFG_BITS,
   parameter logic [CFG_BITS-1:0]  RESET_CFG = gpio_cfg_pkg::RESET_CFG
) (
   input  logic                serial_clock,
   input  logic                reset,
   input  logic                serial_enable,
   input  logic                serial_data_in,
   input  logic                serial_load,
   output logic                serial_data_out,
   output logic                cfg_err,
   output logic [CFG_BITS-1:0] cfg_word,
   input  logic                mgmt_gpio_out,
   input  logic                mgmt_gpio_oeb,
   output logic                mgmt_gpio_in,
   input  logic                user_gpio_out,
   input  logic                user_gpio_oeb,
   output logic                user_gpio_in,
   input  logic                pad_gpio_in,
   output logic                pad_gpio_out,
   output logic                pad_gpio_outenb,
   output logic                pad_gpio_inp_dis,
   output logic [2:0]          pad_gpio_dm
);

   // One spare bit above what CFG_BITS needs so an over-long burst saturates
   // well clear of the valid count.
   localparam int unsigned CntBits = $clog2(CFG_BITS + 1) + 1;
   localparam logic [CntBits-1:0] CntFull = CntBits'(CFG_BITS);

   logic [CFG_BITS-1:0] shreg_q, shreg_d;
   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [CntBits-1:0]  bit_cnt_q, bit_cnt_d;
   logic                cfg_err_q, cfg_err_d;
   logic                pad_in_sync;

   // Serial chain and commit logic
   always_comb begin
      shreg_d   = shreg_q;
      cfg_d     = cfg_q;
      bit_cnt_d = bit_cnt_q;
      cfg_err_d = cfg_err_q;
      if (serial_load) begin
         // Only a complete word is committed; a short or long burst is
         // dropped and flagged so the chain master can retry.
         bit_cnt_d = '0;
         if (bit_cnt_q == CntFull) begin
            cfg_d     = shreg_q;
            cfg_err_d = 1'b0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (serial_enable) begin
         shreg_d = {shreg_q[CFG_BITS-2:0], serial_data_in};
         if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CntBits'(1);
         end
      end
   end

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         shreg_q   <= '0;
         cfg_q     <= RESET_CFG;
         bit_cnt_q <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         cfg_q     <= cfg_d;
         bit_cnt_q <= bit_cnt_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   gpio_in_sync u_in_sync (
      .clk (serial_clock),
      .rst (reset),
      .d   (pad_gpio_in),
      .q   (pad_in_sync)
   );

   // Pad mux, purely combinational from the active configuration
   always_comb begin
      if (cfg_q[MGMT_ENA]) begin
         pad_gpio_out    = mgmt_gpio_out;
         // Config oeb lets firmware force the pad to input regardless of SoC
         pad_gpio_outenb = cfg_q[OEB] | mgmt_gpio_oeb;
         user_gpio_in    = 1'b0;
      end else begin
         pad_gpio_out    = user_gpio_out;
         pad_gpio_outenb = user_gpio_oeb;
         user_gpio_in    = pad_gpio_in;
      end
      pad_gpio_inp_dis = cfg_q[INP_DIS];
      pad_gpio_dm      = cfg_q[DM_MSB:DM_LSB];
      // Gate after the synchronizer so disabling the input takes effect at once
      mgmt_gpio_in     = pad_in_sync & ~cfg_q[INP_DIS];
   end

   assign serial_data_out = shreg_q[CFG_BITS-1];
   assign cfg_err         = cfg_err_q;
   assign cfg_word        = cfg_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        serial_enable = 1'b0;
   logic        serial_data_in = 1'b0;
   logic        serial_load = 1'b0;
   logic        serial_data_out;
   logic        cfg_err;
   logic [12:0] cfg_word;
   logic        mgmt_gpio_out = 1'b0;
   logic        mgmt_gpio_oeb = 1'b0;
   logic        mgmt_gpio_in;
   logic        user_gpio_out = 1'b0;
   logic        user_gpio_oeb = 1'b0;
   logic        user_gpio_in;
   logic        pad_gpio_in = 1'b0;
   logic        pad_gpio_out;
   logic        pad_gpio_outenb;
   logic        pad_gpio_inp_dis;
   logic [2:0]  pad_gpio_dm;

   int n_vec = 0;
   int n_err = 0;
   bit rand_pad = 1'b0;

   always #5 clk = ~clk;

   gpio_pad_ctrl dut (
      .serial_clock     (clk),
      .reset            (reset),
      .serial_enable    (serial_enable),
      .serial_data_in   (serial_data_in),
      .serial_load      (serial_load),
      .serial_data_out  (serial_data_out),
      .cfg_err          (cfg_err),
      .cfg_word         (cfg_word),
      .mgmt_gpio_out    (mgmt_gpio_out),
      .mgmt_gpio_oeb    (mgmt_gpio_oeb),
      .mgmt_gpio_in     (mgmt_gpio_in),
      .user_gpio_out    (user_gpio_out),
      .user_gpio_oeb    (user_gpio_oeb),
      .user_gpio_in     (user_gpio_in),
      .pad_gpio_in      (pad_gpio_in),
      .pad_gpio_out     (pad_gpio_out),
      .pad_gpio_outenb  (pad_gpio_outenb),
      .pad_gpio_inp_dis (pad_gpio_inp_dis),
      .pad_gpio_dm      (pad_gpio_dm)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Chain state kept as the list of the most recent bits shifted in, the
   // count of bits since the last load, and the last two pad samples.
   bit          sh_q[$];
   bit          pad_q[$];
   int          since_load = 0;
   logic [12:0] m_cfg = 13'h1803;
   logic        m_err = 1'b0;

   function automatic logic [12:0] pack_bits();
      logic [12:0] w = '0;
      foreach (sh_q[i]) w = {w[11:0], sh_q[i]};
      return w;
   endfunction

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         sh_q.delete();
         pad_q.delete();
         since_load = 0;
         m_cfg = 13'h1803;
         m_err = 1'b0;
      end else begin
         if (serial_load) begin
            if (since_load == 13) begin
               m_cfg = pack_bits();
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
            since_load = 0;
         end else if (serial_enable) begin
            sh_q.push_back(serial_data_in);
            if (sh_q.size() > 13) void'(sh_q.pop_front());
            since_load++;
         end
         pad_q.push_back(pad_gpio_in);
         if (pad_q.size() > 2) void'(pad_q.pop_front());
      end
   end

   // Compare every cycle, away from the active edge
   initial forever begin
      logic mg, e_out, e_oeb, e_uin, e_min, e_sdo;
      @(negedge clk);
      mg    = m_cfg[0];
      e_out = mg ? mgmt_gpio_out : user_gpio_out;
      e_oeb = mg ? (m_cfg[1] | mgmt_gpio_oeb) : user_gpio_oeb;
      e_uin = mg ? 1'b0 : pad_gpio_in;
      e_min = (!m_cfg[3] && pad_q.size() == 2) ? pad_q[0] : 1'b0;
      e_sdo = (sh_q.size() == 13) ? sh_q[0] : 1'b0;
      chk("cfg_word", 32'(cfg_word), 32'(m_cfg));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("serial_data_out", 32'(serial_data_out), 32'(e_sdo));
      chk("pad_gpio_out", 32'(pad_gpio_out), 32'(e_out));
      chk("pad_gpio_outenb", 32'(pad_gpio_outenb), 32'(e_oeb));
      chk("user_gpio_in", 32'(user_gpio_in), 32'(e_uin));
      chk("mgmt_gpio_in", 32'(mgmt_gpio_in), 32'(e_min));
      chk("pad_gpio_inp_dis", 32'(pad_gpio_inp_dis), 32'(m_cfg[3]));
      chk("pad_gpio_dm", 32'(pad_gpio_dm), 32'(m_cfg[12:10]));
   end

   // Random side-band drive, settled well before both edges
   initial forever begin
      @(posedge clk);
      #3;
      mgmt_gpio_out = 1'($urandom);
      mgmt_gpio_oeb = 1'($urandom);
      user_gpio_out = 1'($urandom);
      user_gpio_oeb = 1'($urandom);
      if (rand_pad) pad_gpio_in = 1'($urandom);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      serial_enable  = 1'b1;
      serial_data_in = b;
      tick();
      serial_enable  = 1'b0;
   endtask

   task automatic shift_word(input logic [12:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic load(input logic with_enable);
      serial_load    = 1'b1;
      serial_enable  = with_enable;
      serial_data_in = 1'b1;
      tick();
      serial_load    = 1'b0;
      serial_enable  = 1'b0;
   endtask

   initial begin
      logic [12:0] w;
      #1 reset = 1'b1;
      #1;
      chk("rst cfg_word", 32'(cfg_word), 32'h1803);
      chk("rst outenb", 32'(pad_gpio_outenb), 32'd1);
      chk("rst dm", 32'(pad_gpio_dm), 32'h6);
      chk("rst cfg_err", 32'(cfg_err), 32'd0);
      chk("rst inp_dis", 32'(pad_gpio_inp_dis), 32'd0);
      chk("rst sdo", 32'(serial_data_out), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Management-mode input synchronizer latency
      pad_gpio_in = 1'b0;
      repeat (3) tick();
      pad_gpio_in = 1'b1;
      tick();
      chk("sync 1 edge", 32'(mgmt_gpio_in), 32'd0);
      tick();
      chk("sync 2 edges", 32'(mgmt_gpio_in), 32'd1);
      pad_gpio_in = 1'b0;
      tick();
      chk("sync fall 1 edge", 32'(mgmt_gpio_in), 32'd1);
      tick();
      chk("sync fall 2 edges", 32'(mgmt_gpio_in), 32'd0);

      // Short burst is rejected
      shift_word(13'h0C08, 12);
      load(1'b0);
      chk("short cfg_word", 32'(cfg_word), 32'h1803);
      chk("short cfg_err", 32'(cfg_err), 32'd1);

      // Full word commits and clears the error
      shift_word(13'h0C08, 13);
      load(1'b0);
      chk("0C08 cfg_word", 32'(cfg_word), 32'h0C08);
      chk("0C08 model", 32'(m_cfg), 32'h0C08);
      chk("0C08 dm", 32'(pad_gpio_dm), 32'h3);
      chk("0C08 inp_dis", 32'(pad_gpio_inp_dis), 32'd1);
      chk("0C08 cfg_err", 32'(cfg_err), 32'd0);
      chk("0C08 user path", 32'(pad_gpio_out), 32'(user_gpio_out));
      pad_gpio_in = 1'b1;
      repeat (3) tick();
      chk("0C08 mgmt_in gated", 32'(mgmt_gpio_in), 32'd0);
      chk("0C08 user_in", 32'(user_gpio_in), 32'd1);

      // Chain pass-through: first bit reappears after 13 enabled shifts
      for (int i = 1; i <= 26; i++) begin
         shift_bit(((i - 1) % 2) == 0);
         if (i >= 13) chk("chain sdo", 32'(serial_data_out), 32'(((i - 13) % 2) == 0));
      end
      load(1'b0);
      chk("chain long cfg_err", 32'(cfg_err), 32'd1);

      // Load and enable together: load wins, no shift, count cleared
      shift_word(13'h0A5A, 13);
      load(1'b1);
      chk("ld+en cfg_word", 32'(cfg_word), 32'h0A5A);
      chk("ld+en sdo kept", 32'(serial_data_out), 32'd0);
      chk("ld+en cfg_err", 32'(cfg_err), 32'd0);
      load(1'b0);
      chk("reload cnt0 err", 32'(cfg_err), 32'd1);
      chk("reload cnt0 word", 32'(cfg_word), 32'h0A5A);

      // Reset mid-shift discards the partial word
      shift_word(13'h1FFF, 7);
      reset = 1'b1;
      #1;
      chk("midrst cfg_word", 32'(cfg_word), 32'h1803);
      chk("midrst sdo", 32'(serial_data_out), 32'd0);
      tick();
      reset = 1'b0;
      shift_word(13'h1F35, 13);
      load(1'b0);
      chk("post-rst cfg_word", 32'(cfg_word), 32'h1F35);
      chk("post-rst cfg_err", 32'(cfg_err), 32'd0);

      // Randomized bursts of varying length with idle gaps
      rand_pad = 1'b1;
      for (int k = 0; k < 60; k++) begin
         int n;
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 15)) : 13;
         for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            shift_bit(1'($urandom));
         end
         repeat ($urandom_range(0, 3)) tick();
         load(1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(1, 6)) tick();
      end
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
